// File: rtl/mips_instr_sequencer_if.sv
// Instruction-memory fetch bus between mips_instr_sequencer (master) and imem (slave).
// A fetch is complete on the first cycle where req and valid are both high.
interface mips_instr_sequencer_if #(
    parameter int ADDR_W = 7
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rdata;
    logic              valid;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  valid
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output valid
    );
endinterface

// File: rtl/mips_instr_sequencer.sv
// Fetch/issue controller for mipscpu: fetches, issues with a newinstr pulse, waits per-class exec time.
// Optional macro SEQ_BRANCH_EN: accept beq (opcode 4) and branch on alu_zero at the end of its EXEC.
module mips_instr_sequencer #(
    parameter int          ADDR_W    = 7,
    parameter int          CNT_W     = 16,
    parameter int          RTYPE_CYC = 3,
    parameter int          LW_CYC    = 4,
    parameter int          SW_CYC    = 3,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    mips_instr_sequencer_if.master        imem,
    input  logic                          alu_zero,
    output logic [31:0]                   instrword,
    output logic                          newinstr,
    output logic [ADDR_W-1:0]             pc,
    output logic [CNT_W-1:0]              retired,
    output logic                          halted,
    output logic                          illegal
);

    localparam int MAX_CYC_A = (RTYPE_CYC > LW_CYC) ? RTYPE_CYC : LW_CYC;
    localparam int MAX_CYC   = (MAX_CYC_A > SW_CYC) ? MAX_CYC_A : SW_CYC;
    localparam int CYC_W     = $clog2(MAX_CYC + 1);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t             state, state_n;
    logic               req_q, req_n;
    logic [CYC_W-1:0]   cnt, cnt_n;
    logic [ADDR_W-1:0]  pc_n;
    logic [31:0]        instr_n;
    logic [CNT_W-1:0]   retired_n;
    logic               newinstr_n;
    logic               halted_n;
    logic               illegal_n;

    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW);
`ifdef SEQ_BRANCH_EN
        ok = ok || (op == OP_BEQ);
`endif
        return ok;
    endfunction

    // Counter is loaded with N-1 so EXEC lasts exactly N cycles; beq shares the R-type timing.
    function automatic logic [CYC_W-1:0] exec_load(input logic [5:0] op);
        logic [CYC_W-1:0] v;
        case (op)
            OP_LW:   v = CYC_W'(LW_CYC - 1);
            OP_SW:   v = CYC_W'(SW_CYC - 1);
            default: v = CYC_W'(RTYPE_CYC - 1);
        endcase
        return v;
    endfunction

    assign imem.req  = req_q;
    assign imem.addr = pc;

`ifndef SEQ_BRANCH_EN
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            req_q     <= 1'b0;
            cnt       <= '0;
            pc        <= '0;
            instrword <= '0;
            retired   <= '0;
            newinstr  <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_n;
            req_q     <= req_n;
            cnt       <= cnt_n;
            pc        <= pc_n;
            instrword <= instr_n;
            retired   <= retired_n;
            newinstr  <= newinstr_n;
            halted    <= halted_n;
            illegal   <= illegal_n;
        end
    end

    // FETCH spends one cycle raising req before it accepts valid, which gives the N+3 issue period.
    always_comb begin
        state_n    = state;
        req_n      = req_q;
        cnt_n      = cnt;
        pc_n       = pc;
        instr_n    = instrword;
        retired_n  = retired;
        newinstr_n = 1'b0;
        halted_n   = halted;
        illegal_n  = illegal;

        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_n      = '0;
                    retired_n = '0;
                    illegal_n = 1'b0;
                    halted_n  = 1'b0;
                    req_n     = 1'b0;
                    state_n   = S_FETCH;
                end
            end

            S_FETCH: begin
                if (!req_q) begin
                    req_n = 1'b1;
                end else if (imem.valid) begin
                    req_n   = 1'b0;
                    instr_n = imem.rdata;
                    if (imem.rdata == HALT_WORD) begin
                        halted_n = 1'b1;
                        state_n  = S_HALT;
                    end else if (!is_legal(imem.rdata[31:26])) begin
                        halted_n  = 1'b1;
                        illegal_n = 1'b1;
                        state_n   = S_HALT;
                    end else begin
                        state_n = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                newinstr_n = 1'b1;
                cnt_n      = exec_load(instrword[31:26]);
                state_n    = S_EXEC;
            end

            S_EXEC: begin
                if (cnt == '0) begin
`ifdef SEQ_BRANCH_EN
                    if ((instrword[31:26] == OP_BEQ) && alu_zero) begin
                        pc_n = pc + ADDR_W'(1) + ADDR_W'($signed(instrword[15:0]));
                    end else begin
                        pc_n = pc + ADDR_W'(1);
                    end
`else
                    pc_n = pc + ADDR_W'(1);
`endif
                    if (retired != '1) begin
                        retired_n = retired + CNT_W'(1);
                    end
                    state_n = S_FETCH;
                end else begin
                    cnt_n = cnt - CYC_W'(1);
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_instr_sequencer.sv
// Scoreboard bench for mips_instr_sequencer: directed programs, expected issues queued, monitors compare.
// Covers halt/illegal handling, wait-state fetches, async reset mid-fetch, pc wrap/retired saturation, beq.
module tb_mips_instr_sequencer;

    localparam int ADDR_W    = 7;
    localparam int CNT_W     = 16;
    localparam int LW_CYC_TB = 4;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [31:0] ADD_A  = 32'h012A_4020;
    localparam logic [31:0] ADD_B  = 32'h016C_4820;
    localparam logic [31:0] LW_W   = 32'h8D28_0004;
    localparam logic [31:0] SW_W   = 32'hAD28_0008;
    localparam logic [31:0] BAD_W  = 32'h0800_0000;
    localparam logic [31:0] BEQ_W  = 32'h1000_FFFF;

    typedef struct {
        logic [31:0] word;
        logic [6:0]  pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic alu_zero = 1'b0;
    logic [31:0]       instrword;
    logic              newinstr;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  retired;
    logic              halted;
    logic              illegal;

    logic rst_s = 1'b1;
    logic start_s = 1'b0;
    logic [31:0] instrword_s;
    logic        newinstr_s;
    logic [1:0]  pc_s;
    logic [1:0]  retired_s;
    logic        halted_s;
    logic        illegal_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int issue_cnt_s = 0;
    int issue_cycs[$];
    int req_rise_q[$];
    exp_t exp_q[$];
    exp_t exp_s_q[$];

    logic [31:0] mem [0:127];
    logic [31:0] mem_s [0:3];
    int mem_delay = 0;
    int wait_cnt = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mips_instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
    mips_instr_sequencer_if #(.ADDR_W(2))      bus_s ();

    mips_instr_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem      (bus),
        .alu_zero  (alu_zero),
        .instrword (instrword),
        .newinstr  (newinstr),
        .pc        (pc),
        .retired   (retired),
        .halted    (halted),
        .illegal   (illegal)
    );

    mips_instr_sequencer #(.ADDR_W(2), .CNT_W(2)) dut_s (
        .clk       (clk),
        .rst       (rst_s),
        .start     (start_s),
        .imem      (bus_s),
        .alu_zero  (1'b0),
        .instrword (instrword_s),
        .newinstr  (newinstr_s),
        .pc        (pc_s),
        .retired   (retired_s),
        .halted    (halted_s),
        .illegal   (illegal_s)
    );

    // Instruction memory model: valid after mem_delay extra request cycles.
    always @(posedge clk) begin
        if (!bus.req || bus.valid) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end
    assign bus.rdata   = mem[bus.addr];
    assign bus.valid   = bus.req && (wait_cnt >= mem_delay);
    assign bus_s.rdata = mem_s[bus_s.addr];
    assign bus_s.valid = bus_s.req;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL timeout %s: got no event expected event", name);
    endtask

    // Scoreboard monitors: every newinstr pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.req && !req_prev) req_rise_q.push_back(cyc);
        req_prev <= bus.req;
        if (newinstr) begin
            exp_t e;
            issue_cnt++;
            issue_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_output("unexpected_newinstr", instrword, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check_output("issue_word", instrword, e.word);
                check_output("issue_pc", 32'(pc), 32'(e.pc));
            end
        end
    end

    always @(negedge clk) begin
        if (newinstr_s) begin
            exp_t e;
            issue_cnt_s++;
            if (exp_s_q.size() == 0) begin
                check_output("unexpected_newinstr_s", instrword_s, 32'hxxxx_xxxx);
            end else begin
                e = exp_s_q.pop_front();
                check_output("issue_word_s", instrword_s, e.word);
                check_output("issue_pc_s", 32'(pc_s), 32'(e.pc));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_issue(input logic [31:0] w, input logic [6:0] p);
        exp_t e;
        e.word = w;
        e.pc   = p;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 300) begin
            tick();
            n++;
        end
        if (!halted) fail_timeout(name);
    endtask

    task automatic wait_issues(input int target, input string name);
        int n = 0;
        while (issue_cnt < target && n < 300) begin
            tick();
            n++;
        end
        if (issue_cnt < target) fail_timeout(name);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus.req && n < 300) begin
            tick();
            n++;
        end
        if (!bus.req) fail_timeout(name);
    endtask

    initial begin
        int base;
        int seen;
        for (int i = 0; i < 128; i++) mem[i] = HALT_W;
        mem_s[0] = 32'h0022_1820;
        mem_s[1] = 32'h0043_2020;
        mem_s[2] = 32'h0064_2820;
        mem_s[3] = 32'h0085_3020;

        repeat (3) tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_output("rst_pc", 32'(pc), 32'd0);
        check_output("rst_instrword", instrword, 32'd0);
        check_output("rst_retired", 32'(retired), 32'd0);
        check_output("rst_newinstr", 32'(newinstr), 32'd0);
        check_output("rst_req", 32'(bus.req), 32'd0);
        check_output("rst_halted", 32'(halted), 32'd0);
        check_output("rst_illegal", 32'(illegal), 32'd0);

        // add then halt with a zero-wait memory
        mem[0] = ADD_A;
        mem[1] = HALT_W;
        mem_delay = 0;
        issue_cycs.delete();
        req_rise_q.delete();
        base = issue_cnt;
        expect_issue(ADD_A, 7'd0);
        apply_stimulus();
        wait_halt("t1_halt");
        check_output("t1_issues", 32'(issue_cnt - base), 32'd1);
        check_output("t1_retired", 32'(retired), 32'd1);
        check_output("t1_halted", 32'(halted), 32'd1);
        check_output("t1_illegal", 32'(illegal), 32'd0);
        check_output("t1_pc", 32'(pc), 32'd1);
        check_output("t1_latency",
            (issue_cycs.size() > 0 && req_rise_q.size() > 0) ? 32'(issue_cycs[0] - req_rise_q[0]) : 32'hFFFF_FFFF,
            32'd2);
        check_output("t1_drain", 32'(exp_q.size()), 32'd0);

        // lw, sw with three wait states on every fetch
        mem[0] = LW_W;
        mem[1] = SW_W;
        mem[2] = HALT_W;
        mem_delay = 3;
        issue_cycs.delete();
        base = issue_cnt;
        expect_issue(LW_W, 7'd0);
        expect_issue(SW_W, 7'd1);
        apply_stimulus();
        wait_issues(base + 1, "t2_first_issue");
        for (int i = 0; i < LW_CYC_TB; i++) begin
            tick();
            check_output("t2_exec_hold", instrword, LW_W);
        end
        wait_halt("t2_halt");
        check_output("t2_spacing",
            (issue_cycs.size() > 1) ? 32'(issue_cycs[1] - issue_cycs[0]) : 32'hFFFF_FFFF,
            32'(LW_CYC_TB + 3 + 3));
        check_output("t2_retired", 32'(retired), 32'd2);
        check_output("t2_pc", 32'(pc), 32'd2);
        check_output("t2_drain", 32'(exp_q.size()), 32'd0);

        // unsupported opcode halts as illegal; a new start clears it and refetches from pc 0
        mem[0] = BAD_W;
        mem_delay = 0;
        base = issue_cnt;
        apply_stimulus();
        wait_halt("t3_halt");
        check_output("t3_issues", 32'(issue_cnt - base), 32'd0);
        check_output("t3_illegal", 32'(illegal), 32'd1);
        check_output("t3_instrword", instrword, BAD_W);
        check_output("t3_pc", 32'(pc), 32'd0);
        mem[0] = ADD_B;
        mem[1] = HALT_W;
        expect_issue(ADD_B, 7'd0);
        apply_stimulus();
        check_output("t3_illegal_clr", 32'(illegal), 32'd0);
        check_output("t3_halted_clr", 32'(halted), 32'd0);
        wait_req("t3_refetch");
        check_output("t3_refetch_addr", 32'(bus.addr), 32'd0);
        wait_halt("t3_halt2");
        check_output("t3_retired", 32'(retired), 32'd1);
        check_output("t3_drain", 32'(exp_q.size()), 32'd0);

        // asynchronous reset in the middle of a stalled fetch
        mem[0] = ADD_A;
        mem[1] = ADD_B;
        mem[2] = ADD_A;
        base = issue_cnt;
        expect_issue(ADD_A, 7'd0);
        expect_issue(ADD_B, 7'd1);
        apply_stimulus();
        wait_issues(base + 2, "t4_issues");
        mem_delay = 50;
        wait_req("t4_req");
        check_output("t4_pre_pc", 32'(pc), 32'd2);
        check_output("t4_pre_retired", 32'(retired), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_output("t4_req", 32'(bus.req), 32'd0);
        check_output("t4_pc", 32'(pc), 32'd0);
        check_output("t4_instrword", instrword, 32'd0);
        check_output("t4_retired", 32'(retired), 32'd0);
        check_output("t4_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_delay = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.req || newinstr) seen++;
        end
        check_output("t4_stay_idle", 32'(seen), 32'd0);
        check_output("t4_drain", 32'(exp_q.size()), 32'd0);

        // narrow instance: pc wraps 3->0, retired saturates at 3
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            e.word = mem_s[k % 4];
            e.pc   = 7'(k % 4);
            exp_s_q.push_back(e);
        end
        @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        begin
            int n = 0;
            while (issue_cnt_s < 6 && n < 300) begin
                tick();
                n++;
            end
            if (issue_cnt_s < 6) fail_timeout("t5_issues");
        end
        check_output("t5_retired_sat", 32'(retired_s), 32'd3);
        check_output("t5_drain", 32'(exp_s_q.size()), 32'd0);
        rst_s = 1'b1;

        // beq at pc 2
        mem[0] = ADD_A;
        mem[1] = ADD_B;
        mem[2] = BEQ_W;
        mem[3] = HALT_W;
        base = issue_cnt;
        expect_issue(ADD_A, 7'd0);
        expect_issue(ADD_B, 7'd1);
`ifdef SEQ_BRANCH_EN
        alu_zero = 1'b1;
        expect_issue(BEQ_W, 7'd2);
        expect_issue(BEQ_W, 7'd2);
        apply_stimulus();
        wait_issues(base + 4, "t6_beq_loop");
        alu_zero = 1'b0;
        wait_halt("t6_halt");
        check_output("t6_pc", 32'(pc), 32'd3);
        check_output("t6_illegal", 32'(illegal), 32'd0);
        check_output("t6_retired", 32'(retired), 32'd4);
`else
        apply_stimulus();
        wait_halt("t6_halt");
        check_output("t6_illegal", 32'(illegal), 32'd1);
        check_output("t6_pc", 32'(pc), 32'd2);
        check_output("t6_retired", 32'(retired), 32'd2);
        check_output("t6_instrword", instrword, BEQ_W);
`endif
        check_output("t6_drain", 32'(exp_q.size()), 32'd0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
